// File: rtl/write_resp_router.sv
// write_resp_router
// Return-path end of the write-response ordering scheme. The master ID of
// every write address accepted toward the slave is recorded in an in-order
// ID queue. Each slave B response is routed to the master at the queue head,
// and the queue entry is retired when that master completes the handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | queue empty; slave not offered ready
// ARMED | queue non-empty; S_BREADY high, waiting for a slave response
// HOLD  | response latched; M_BVALID high toward the head master only
module write_resp_router #(
  parameter int Masters_Num = 2,
  parameter int ID_Size     = $clog2(Masters_Num),
  parameter int Queue_Depth = 4,
  parameter int Cnt_Size    = $clog2(Queue_Depth + 1)
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [ID_Size-1:0]     Master_ID,
  input  logic                   AW_Push,
  output logic                   Order_Full,
  input  logic                   S_BVALID,
  input  logic [1:0]             S_BRESP,
  output logic                   S_BREADY,
  output logic [Masters_Num-1:0] M_BVALID,
  output logic [1:0]             M_BRESP,
  input  logic [Masters_Num-1:0] M_BREADY,
  output logic                   Write_Resp_Finsh,
  output logic [Cnt_Size-1:0]    Outstanding,
  output logic                   Resp_Error
);

  localparam int PtrSize = (Queue_Depth > 1) ? $clog2(Queue_Depth) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [ID_Size-1:0]     id_mem_q [Queue_Depth];
  logic [PtrSize-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrSize-1:0]     rd_ptr_q, rd_ptr_d;
  logic [Cnt_Size-1:0]    cnt_q, cnt_d;
  logic [ID_Size-1:0]     sel_id_q;
  logic                   s_bready_q;
  logic [Masters_Num-1:0] m_bvalid_q;
  logic [1:0]             m_bresp_q;
  logic                   err_q;

  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   push_drop;
  logic                   idle_resp;
  logic [ID_Size-1:0]     head_id;

  // One-hot select vector for a master ID.
  function automatic logic [Masters_Num-1:0] id_to_onehot(input logic [ID_Size-1:0] id);
    logic [Masters_Num-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  assign full    = (cnt_q == Cnt_Size'(Queue_Depth));
  assign head_id = id_mem_q[rd_ptr_q];

  // Queue control: a pop in the same cycle frees a slot, so a push is still
  // taken when full as long as the head is retiring right now.
  always_comb begin
    pop       = (state_q == HOLD) && M_BREADY[sel_id_q];
    push      = AW_Push && (!full || pop);
    push_drop = AW_Push && full && !pop;
    idle_resp = (state_q == IDLE) && S_BVALID;

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrSize'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrSize'(1);
    end

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + Cnt_Size'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - Cnt_Size'(1);
    end
  end

  // ID storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge ACLK) begin
    if (push) begin
      id_mem_q[wr_ptr_q] <= Master_ID;
    end
  end

  // Queue pointers and occupancy counter.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Routing FSM with registered handshake outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      s_bready_q <= 1'b0;
      m_bvalid_q <= '0;
      m_bresp_q  <= 2'b00;
      sel_id_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            state_q    <= ARMED;
            s_bready_q <= 1'b1;
          end
        end
        ARMED: begin
          if (S_BVALID) begin
            state_q    <= HOLD;
            s_bready_q <= 1'b0;
            m_bresp_q  <= S_BRESP;
            sel_id_q   <= head_id;
            m_bvalid_q <= id_to_onehot(head_id);
          end
        end
        HOLD: begin
          if (pop) begin
            m_bvalid_q <= '0;
            if (cnt_d != '0) begin
              state_q    <= ARMED;
              s_bready_q <= 1'b1;
            end else begin
              state_q    <= IDLE;
              s_bready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          s_bready_q <= 1'b0;
          m_bvalid_q <= '0;
        end
      endcase
    end
  end

  // Sticky protocol error: response with nothing queued, or a dropped push.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      err_q <= 1'b0;
    end else if (push_drop || idle_resp) begin
      err_q <= 1'b1;
    end
  end

  assign S_BREADY         = s_bready_q;
  assign M_BVALID         = m_bvalid_q;
  assign M_BRESP          = m_bresp_q;
  assign Write_Resp_Finsh = pop;
  assign Outstanding      = cnt_q;
  assign Order_Full       = full;
  assign Resp_Error       = err_q;

endmodule

// File: doc/write_resp_router.md
Name: write_resp_router

Overview:
- Return-path end of the write-response ordering scheme. Records the master ID of every write address accepted toward a slave in an in-order ID queue.
- Accepts the slave's B-channel response and routes it to the master at the queue head.
- Pulses Write_Resp_Finsh when the routed response completes.
- Sits between one slave-side B channel and the per-master B channels in the interconnect.

Parameters:
- Masters_Num, 2, number of masters served.
- ID_Size, $clog2(Masters_Num), width of a master ID.
- Queue_Depth, 4, number of outstanding write transactions tracked; power of two, at least 2.
- Cnt_Size, $clog2(Queue_Depth+1), width of the outstanding counter.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset; synchronous, active-low.
- Master_ID  in  ID_Size  ID of the master whose AW was just accepted.
- AW_Push  in  1  one-cycle strobe: enqueue Master_ID.
- Order_Full  out  1  queue holds Queue_Depth entries; upstream must not push.
- S_BVALID  in  1  slave response valid.
- S_BRESP  in  2  slave response code.
- S_BREADY  out  1  ready toward the slave.
- M_BVALID  out  Masters_Num  one-hot valid toward masters.
- M_BRESP  out  2  registered response code, broadcast to all masters.
- M_BREADY  in  Masters_Num  per-master ready.
- Write_Resp_Finsh  out  1  one-cycle pulse on master handshake.
- Outstanding  out  Cnt_Size  current queue occupancy.
- Resp_Error  out  1  sticky: response with empty queue, or push while full.

Behaviour:
- Reset (ARESETN=0 sampled at a rising edge):
  - state=IDLE; read and write pointers = 0; Outstanding=0.
  - S_BREADY=0; M_BVALID=0; M_BRESP=2'b00; Write_Resp_Finsh=0; Order_Full=0; Resp_Error=0.
  - Reset mid-transaction discards all queued IDs and any held response.
- ID queue: circular buffer, pointers wrap modulo Queue_Depth.
  - Push when AW_Push=1 and not full.
  - Pop at the master handshake (HOLD state, M_BREADY[head]=1).
  - Push and pop in the same cycle: both occur and Outstanding is unchanged; this is allowed even when full, since the pop frees the slot.
  - Push while full with no pop: entry dropped, Resp_Error set.
- Order_Full = (Outstanding == Queue_Depth), registered-consistent with the counter.
- FSM:
  - IDLE: queue empty, S_BREADY=0.
    - Push → ARMED.
    - S_BVALID=1 in IDLE → Resp_Error set; the response is not accepted.
  - ARMED: queue non-empty, S_BREADY=1.
    - On S_BVALID&S_BREADY: latch S_BRESP into M_BRESP, latch the head ID → HOLD.
  - HOLD: S_BREADY=0; M_BVALID[latched ID]=1, all other bits 0.
    - On M_BREADY[latched ID]=1: pop, Write_Resp_Finsh=1 for exactly that cycle, M_BVALID cleared next cycle.
    - Next state: ARMED if the queue is still non-empty after the pop and push of this cycle, otherwise IDLE.
- Timing and handshake rules:
  - Latency: slave handshake at edge N → M_BVALID high after edge N, so visible in cycle N+1.
  - Throughput: at most one response per two cycles.
  - M_BVALID and M_BRESP stay stable until the handshake.
  - M_BREADY of non-selected masters is ignored.
  - Responses are routed strictly in push order.
- Resp_Error clears only on reset.

Test Plan:
- Reset, push ID 1, S_BVALID=1 with BRESP=2'b10 → S_BREADY=1 in the cycle after the push; M_BVALID=2'b10 and M_BRESP=2'b10 one cycle after the slave handshake; with M_BREADY=2'b10, Finsh pulses once and Outstanding returns to 0.
- Push IDs 1,0,1; issue three slave responses with BRESP 00,01,10 → masters receive 1/00, 0/01, 1/10 in that order; three Finsh pulses.
- Hold M_BREADY=0 for 3 cycles in HOLD → M_BVALID and M_BRESP stable, S_BREADY=0; release → single Finsh.
- Push 4 IDs → Order_Full=1 and Outstanding=4; a 5th push alone sets Resp_Error and leaves Outstanding=4; after reset, fill again, then push in the same cycle as a pop → Outstanding stays 4 and Resp_Error stays 0.
- S_BVALID=1 with the queue empty → S_BREADY stays 0, Resp_Error=1, M_BVALID=0.
- Push 2 IDs, reach HOLD, assert ARESETN=0 for one edge → next cycle all outputs at reset values and Outstanding=0.
